// File: rtl/seven_seg_scanner_pkg.sv
// Shared display definitions: scanner FSM states, segment glyphs, digit helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package seven_seg_scanner_pkg;

  // Scanner FSM: idle (dark), blanking at slot start, showing the latched glyph.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // Slot counter width; wide enough for the largest legal slot length.
  localparam int unsigned CNT_W = 16;

  // Digit index of the seconds LSD; the scan wraps back to 0 after it.
  localparam logic [2:0] LAST_DIGIT = 3'd5;

  // Active-high glyphs in {g,f,e,d,c,b,a} order.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // One-hot digit enable for a digit index (index is always 0..5 here).
  function automatic logic [5:0] digit_onehot(input logic [2:0] idx);
    digit_onehot = 6'd1 << idx;
  endfunction

  // Next digit index in scan order, wrapping after the last digit.
  function automatic logic [2:0] next_digit(input logic [2:0] idx);
    next_digit = (idx >= LAST_DIGIT) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_to_7seg.sv
// BCD to seven-segment glyph decoder with decimal point and forced blank.
// Latency: purely combinational.
// Backpressure: none.
module bcd_to_7seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] segments
);

  logic [6:0] glyph;

  // Map the digit to its glyph; non-decimal codes show a dash, blank darkens a..g only.
  always_comb begin
    glyph = SEG_DASH;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
    if (blank) begin
      glyph = SEG_OFF;
    end
  end

  // The decimal point is independent of blanking.
  assign segments = {dp, glyph};

endmodule

// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed seven-segment scanner with per-slot blanking and leading-zero suppression.
// Latency: a digit lights BLANK_CYCLES clocks into its slot; its BCD value is sampled once, on the last blank clock.
// Backpressure: none; free-running while i_en is high, returns dark to IDLE the clock after i_en drops.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  output logic [2:0] o_seg_select,
  input  logic [3:0] i_bcd,
  input  logic       i_dp,
  output logic [7:0] o_segments,
  output logic [5:0] o_digit_en
);

  // Counter values at the last blank clock and the last clock of the slot.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;
  logic [5:0]       den_q, den_d;

  logic             lz_hit;
  logic [7:0]       dec_seg;

  // Only the hours MSD is suppressed, and only when it really is a zero.
  assign lz_hit = (LZ_BLANK != 0) && (sel_q == 3'd0) && (i_bcd == 4'd0);

  bcd_to_7seg u_dec (
    .bcd      (i_bcd),
    .dp       (i_dp),
    .blank    (lz_hit),
    .segments (dec_seg)
  );

  // State, slot counter, digit select and display outputs; all cleared by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      seg_q   <= 8'h00;
      den_q   <= 6'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      den_q   <= den_d;
    end
  end

  // Next-state and next-output logic: hold everything unless a slot boundary is reached.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    seg_d   = seg_q;
    den_d   = den_q;

    if (!i_en) begin
      // Disable wins from any state: go dark and restart from digit 0 later.
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = 3'd0;
      seg_d   = 8'h00;
      den_d   = 6'h00;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = 3'd0;
          seg_d   = 8'h00;
          den_d   = 6'h00;
        end

        BLANK: begin
          seg_d = 8'h00;
          den_d = 6'h00;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            // Select has been stable for the whole blank period; sample the digit now.
            seg_d   = dec_seg;
            den_d   = digit_onehot(sel_q);
            state_d = SHOW;
          end
        end

        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            // Slot over: go dark and move the select so it settles while blanked.
            state_d = BLANK;
            cnt_d   = '0;
            sel_d   = next_digit(sel_q);
            seg_d   = 8'h00;
            den_d   = 6'h00;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 3'd0;
          seg_d   = 8'h00;
          den_d   = 6'h00;
        end
      endcase
    end
  end

  assign o_seg_select = sel_q;
  assign o_segments   = seg_q;
  assign o_digit_en   = den_q;

endmodule
